// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        L_WAIT,
        S_WAIT,
        L_DRAIN
    } dmem_arb_state_t;

    localparam int DMEM_ARB_ROB_DEPTH  = 3;
    localparam int DMEM_ARB_STARVE_MAX = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the load unit and the committed-store buffer,
// one transaction in flight, with buffer-pressure/starvation priority and flush squashing.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ROB_DEPTH  = DMEM_ARB_ROB_DEPTH,
    parameter int STARVE_MAX = DMEM_ARB_STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_flush,
    input  logic                 ld_req_valid,
    output logic                 ld_req_ready,
    input  logic [31:0]          ld_req_addr,
    input  logic [3:0]           ld_req_rmask,
    input  logic [ROB_DEPTH-1:0] ld_req_rob,
    output logic                 ld_resp_valid,
    output logic [ROB_DEPTH-1:0] ld_resp_rob,
    output logic [31:0]          ld_resp_rdata,
    input  logic                 sb_req_valid,
    output logic                 sb_req_ready,
    input  logic [31:0]          sb_req_addr,
    input  logic [3:0]           sb_req_wmask,
    input  logic [31:0]          sb_req_wdata,
    input  logic                 sb_full,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_resp,
    input  logic [31:0]          dmem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_SAT = CW'(STARVE_MAX);

    dmem_arb_state_t        r_state;
    logic [CW-1:0]          r_starve_cnt;
    logic                   r_is_store;
    logic                   r_drop;
    logic [ROB_DEPTH-1:0]   r_rob;
    logic [31:0]            r_dmem_addr;
    logic [3:0]             r_dmem_rmask;
    logic [3:0]             r_dmem_wmask;
    logic [31:0]            r_dmem_wdata;
    logic                   r_ld_resp_valid;
    logic [ROB_DEPTH-1:0]   r_ld_resp_rob;
    logic [31:0]            r_ld_resp_rdata;

    logic w_idle;
    logic w_store_wins;
    logic w_ld_grant;
    logic w_sb_grant;

    assign w_idle       = (r_state == IDLE);
    assign w_store_wins = sb_full | (r_starve_cnt == STARVE_SAT);

    // A flushing load is never granted; the flush hands the port to a waiting store instead.
    assign ld_req_ready = w_idle & ~move_flush & ld_req_valid & ~w_store_wins;
    assign sb_req_ready = w_idle & sb_req_valid & (w_store_wins | ~ld_req_valid | move_flush);
    assign w_ld_grant   = ld_req_valid & ld_req_ready;
    assign w_sb_grant   = sb_req_valid & sb_req_ready;

    assign dmem_addr     = r_dmem_addr;
    assign dmem_rmask    = r_dmem_rmask;
    assign dmem_wmask    = r_dmem_wmask;
    assign dmem_wdata    = r_dmem_wdata;
    assign ld_resp_valid = r_ld_resp_valid;
    assign ld_resp_rob   = r_ld_resp_rob;
    assign ld_resp_rdata = r_ld_resp_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_starve_cnt    <= '0;
            r_is_store      <= 1'b0;
            r_drop          <= 1'b0;
            r_rob           <= '0;
            r_dmem_addr     <= '0;
            r_dmem_rmask    <= '0;
            r_dmem_wmask    <= '0;
            r_dmem_wdata    <= '0;
            r_ld_resp_valid <= 1'b0;
            r_ld_resp_rob   <= '0;
            r_ld_resp_rdata <= '0;
        end else begin
            r_ld_resp_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_ld_grant) begin
                        r_state      <= REQ;
                        r_is_store   <= 1'b0;
                        r_drop       <= 1'b0;
                        r_rob        <= ld_req_rob;
                        r_dmem_addr  <= word_align(ld_req_addr);
                        r_dmem_rmask <= ld_req_rmask;
                        r_dmem_wmask <= '0;
                        r_dmem_wdata <= '0;
                    end else if (w_sb_grant) begin
                        r_state      <= REQ;
                        r_is_store   <= 1'b1;
                        r_drop       <= 1'b0;
                        r_dmem_addr  <= word_align(sb_req_addr);
                        r_dmem_rmask <= '0;
                        r_dmem_wmask <= sb_req_wmask;
                        r_dmem_wdata <= sb_req_wdata;
                    end
                end
                REQ: begin
                    r_dmem_addr  <= '0;
                    r_dmem_rmask <= '0;
                    r_dmem_wmask <= '0;
                    r_dmem_wdata <= '0;
                    if (r_is_store) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= L_WAIT;
                        r_drop  <= move_flush;
                    end
                end
                L_WAIT: begin
                    if (dmem_resp) begin
                        r_state <= IDLE;
                        if (~r_drop & ~move_flush) begin
                            r_ld_resp_valid <= 1'b1;
                            r_ld_resp_rob   <= r_rob;
                            r_ld_resp_rdata <= dmem_rdata;
                        end
                    end else if (move_flush) begin
                        r_state <= L_DRAIN;
                    end
                end
                S_WAIT, L_DRAIN: begin
                    if (dmem_resp) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_sb_grant) begin
                r_starve_cnt <= '0;
            end else if (w_ld_grant & sb_req_valid & (r_starve_cnt != STARVE_SAT)) begin
                r_starve_cnt <= r_starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized bench for dmem_port_arbiter against a transaction-level model
// with a latency-programmable memory responder.
module tb_dmem_port_arbiter;

    localparam int ROB_DEPTH  = 3;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_flush;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [3:0]  ld_req_rmask;
    logic [2:0]  ld_req_rob;
    logic        ld_resp_valid;
    logic [2:0]  ld_resp_rob;
    logic [31:0] ld_resp_rdata;
    logic        sb_req_valid;
    logic        sb_req_ready;
    logic [31:0] sb_req_addr;
    logic [3:0]  sb_req_wmask;
    logic [31:0] sb_req_wdata;
    logic        sb_full;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ROB_DEPTH(ROB_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .move_flush(move_flush),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_addr(ld_req_addr), .ld_req_rmask(ld_req_rmask), .ld_req_rob(ld_req_rob),
        .ld_resp_valid(ld_resp_valid), .ld_resp_rob(ld_resp_rob), .ld_resp_rdata(ld_resp_rdata),
        .sb_req_valid(sb_req_valid), .sb_req_ready(sb_req_ready),
        .sb_req_addr(sb_req_addr), .sb_req_wmask(sb_req_wmask), .sb_req_wdata(sb_req_wdata),
        .sb_full(sb_full),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata)
    );

    // Memory responder: response becomes visible mem_lat cycles after the request cycle.
    int          mem_lat = 0;
    bit          rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed = 32'h0;
    logic        inj = 1'b0;
    logic        mem_resp_r = 1'b0;
    logic [31:0] mem_rdata_r = 32'h0;
    int          r_cnt = 0;
    bit          r_pend = 1'b0;

    assign dmem_resp  = mem_resp_r | inj;
    assign dmem_rdata = mem_rdata_r;

    always @(posedge clk) begin
        if (rst) begin
            r_pend     <= 1'b0;
            mem_resp_r <= 1'b0;
        end else begin
            mem_resp_r <= 1'b0;
            if (dmem_rmask != 4'd0 || dmem_wmask != 4'd0) begin
                if (mem_lat == 1 || (mem_lat == 0 && $urandom_range(0, 3) == 0)) begin
                    mem_resp_r  <= 1'b1;
                    mem_rdata_r <= rd_fixed_en ? rd_fixed : $urandom;
                end else begin
                    r_pend <= 1'b1;
                    r_cnt  <= (mem_lat > 0) ? mem_lat - 1 : int'($urandom_range(1, 3));
                end
            end else if (r_pend) begin
                if (r_cnt == 1) begin
                    r_pend      <= 1'b0;
                    mem_resp_r  <= 1'b1;
                    mem_rdata_r <= rd_fixed_en ? rd_fixed : $urandom;
                end else begin
                    r_cnt <= r_cnt - 1;
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    // Transaction-level model: one outstanding op, pending dmem pulse, expected response.
    bit          m_known = 1'b0, m_outst = 1'b0, m_is_ld = 1'b0, m_drop = 1'b0;
    bit          m_pend = 1'b0, m_resp_v = 1'b0;
    int          m_starve = 0;
    logic [2:0]  m_rob = '0, m_resp_rob = '0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_resp_rdata = '0;
    logic [3:0]  m_rmask = '0, m_wmask = '0;

    int          cyc = 0, n_rd_cyc = 0, n_wr_cyc = 0, n_resp = 0, n_txn = 0;
    int          last_resp_cyc = 0, last_grant_cyc = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_resp_rdata = '0;
    logic [3:0]  last_wmask = '0;
    logic [2:0]  last_resp_rob = '0;
    byte         glog[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        n_rd_cyc = 0; n_wr_cyc = 0; n_resp = 0;
        glog.delete();
    endtask

    task automatic quiet_inputs();
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_rmask = '0; ld_req_rob = '0;
        sb_req_valid = 1'b0; sb_req_addr = '0; sb_req_wmask = '0; sb_req_wdata = '0;
        sb_full = 1'b0; move_flush = 1'b0; inj = 1'b0;
    endtask

    // Called at a negedge with inputs already applied; checks, advances the model, waits a cycle.
    task automatic tick();
        bit idle, sw, e_ld, e_sb;
        #1;
        cyc++;
        idle = !m_outst;
        sw   = sb_full || (m_starve == STARVE_MAX);
        e_ld = idle && !move_flush && ld_req_valid && !sw;
        e_sb = idle && sb_req_valid && (sw || !ld_req_valid || move_flush);
        if (m_known) begin
            if (m_pend) begin
                chk("dmem_req", 128'({dmem_addr, dmem_rmask, dmem_wmask}), 128'({m_addr, m_rmask, m_wmask}));
                if (m_wmask != 4'd0) chk("dmem_wdata", 128'(dmem_wdata), 128'(m_wdata));
            end else begin
                chk("dmem_quiet", 128'({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata}), 128'(0));
            end
            chk("ld_resp_valid", 128'(ld_resp_valid), 128'(m_resp_v));
            if (m_resp_v) chk("ld_resp_payload", 128'({ld_resp_rob, ld_resp_rdata}), 128'({m_resp_rob, m_resp_rdata}));
            chk("ld_req_ready", 128'(ld_req_ready), 128'(e_ld));
            chk("sb_req_ready", 128'(sb_req_ready), 128'(e_sb));
        end
        if (dmem_rmask != 4'd0) begin n_rd_cyc++; last_rd_addr = dmem_addr; end
        if (dmem_wmask != 4'd0) begin n_wr_cyc++; last_wr_addr = dmem_addr; last_wmask = dmem_wmask; end
        if (ld_resp_valid === 1'b1) begin
            n_resp++; last_resp_rob = ld_resp_rob; last_resp_rdata = ld_resp_rdata;
        end
        if (dmem_resp) last_resp_cyc = cyc;
        if (ld_req_valid && ld_req_ready === 1'b1) begin
            glog.push_back(8'h4C); last_grant_cyc = cyc; n_txn++;
            $display("txn %0d cyc %0d: load  addr=%h rmask=%b rob=%0d", n_txn, cyc, ld_req_addr, ld_req_rmask, ld_req_rob);
        end
        if (sb_req_valid && sb_req_ready === 1'b1) begin
            glog.push_back(8'h53); last_grant_cyc = cyc; n_txn++;
            $display("txn %0d cyc %0d: store addr=%h wmask=%b data=%h", n_txn, cyc, sb_req_addr, sb_req_wmask, sb_req_wdata);
        end
        if (rst) begin
            m_known = 1'b1; m_outst = 1'b0; m_pend = 1'b0; m_resp_v = 1'b0;
            m_drop = 1'b0; m_starve = 0;
        end else begin
            m_resp_v = 1'b0;
            m_pend   = 1'b0;
            if (m_outst && dmem_resp) begin
                if (m_is_ld && !m_drop && !move_flush) begin
                    m_resp_v = 1'b1; m_resp_rob = m_rob; m_resp_rdata = dmem_rdata;
                end
                m_outst = 1'b0;
            end else if (m_outst && m_is_ld && move_flush) begin
                m_drop = 1'b1;
            end
            if (e_ld) begin
                m_outst = 1'b1; m_is_ld = 1'b1; m_drop = 1'b0; m_rob = ld_req_rob;
                m_pend = 1'b1; m_addr = ld_req_addr & 32'hFFFF_FFFC;
                m_rmask = ld_req_rmask; m_wmask = 4'd0; m_wdata = 32'd0;
                if (sb_req_valid && m_starve < STARVE_MAX) m_starve++;
            end else if (e_sb) begin
                m_outst = 1'b1; m_is_ld = 1'b0; m_drop = 1'b0;
                m_pend = 1'b1; m_addr = sb_req_addr & 32'hFFFF_FFFC;
                m_rmask = 4'd0; m_wmask = sb_req_wmask; m_wdata = sb_req_wdata;
                m_starve = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] pat;
        int guard;
        quiet_inputs();
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_outputs", 128'({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, ld_resp_valid,
                                   ld_resp_rob, ld_resp_rdata, ld_req_ready, sb_req_ready}), 128'(0));
        tick();

        // Lone load
        clear_obs();
        mem_lat = 3; rd_fixed_en = 1'b1; rd_fixed = 32'hAABBCCDD;
        ld_req_valid = 1'b1; ld_req_addr = 32'h1006; ld_req_rmask = 4'b0100; ld_req_rob = 3'd5;
        tick();
        ld_req_valid = 1'b0;
        repeat (8) tick();
        chk("t1_grants", 128'(glog.size()), 128'(1));
        chk("t1_rd_cycles", 128'(n_rd_cyc), 128'(1));
        chk("t1_rd_addr", 128'(last_rd_addr), 128'(32'h1004));
        chk("t1_resp_count", 128'(n_resp), 128'(1));
        chk("t1_resp", 128'({last_resp_rob, last_resp_rdata}), 128'({3'd5, 32'hAABBCCDD}));
        rd_fixed_en = 1'b0;

        // Lone store
        clear_obs();
        sb_req_valid = 1'b1; sb_req_addr = 32'h2000; sb_req_wmask = 4'b0011; sb_req_wdata = 32'h1234;
        tick();
        sb_req_valid = 1'b0;
        repeat (8) tick();
        chk("t2_wr_cycles", 128'(n_wr_cyc), 128'(1));
        chk("t2_wr", 128'({last_wr_addr, last_wmask}), 128'({32'h2000, 4'b0011}));
        chk("t2_no_read_no_resp", 128'({n_rd_cyc, n_resp}), 128'(0));

        // Both requesters always valid: four loads then a forced store
        clear_obs();
        mem_lat = 1;
        ld_req_valid = 1'b1; ld_req_addr = 32'h40; ld_req_rmask = 4'hF; ld_req_rob = 3'd2;
        sb_req_valid = 1'b1; sb_req_addr = 32'h80; sb_req_wmask = 4'hF; sb_req_wdata = 32'h5A5A5A5A;
        guard = 0;
        while (glog.size() < 10 && guard < 300) begin tick(); guard++; end
        chk("t3_grants_seen", 128'(glog.size() >= 10), 128'(1));
        pat = '0;
        for (int i = 0; i < 10 && i < glog.size(); i++) pat[i] = (glog[i] == 8'h53);
        chk("t3_pattern", 128'(pat), 128'(10'b10_0001_0000));
        quiet_inputs();
        repeat (6) tick();

        // sb_full gives the store priority
        clear_obs();
        mem_lat = 2;
        sb_full = 1'b1;
        ld_req_valid = 1'b1; ld_req_addr = 32'h100; ld_req_rmask = 4'h1; ld_req_rob = 3'd1;
        sb_req_valid = 1'b1; sb_req_addr = 32'h104; sb_req_wmask = 4'h8; sb_req_wdata = 32'hDEAD0000;
        guard = 0;
        while (glog.size() < 1 && guard < 10) begin tick(); guard++; end
        chk("t4_store_first", 128'(glog.size() > 0 ? glog[0] : 8'h0), 128'(8'h53));
        quiet_inputs();
        repeat (6) tick();

        // Flush in L_WAIT squashes the response; next load granted right after dmem_resp
        clear_obs();
        mem_lat = 5;
        ld_req_valid = 1'b1; ld_req_addr = 32'h300; ld_req_rmask = 4'h3; ld_req_rob = 3'd6;
        tick();
        tick();
        move_flush = 1'b1;
        #1;
        chk("t5_ready_in_flush", 128'(ld_req_ready), 128'(0));
        tick();
        move_flush = 1'b0;
        guard = 0;
        while (glog.size() < 2 && guard < 20) begin tick(); guard++; end
        chk("t5_regrant", 128'(glog.size()), 128'(2));
        chk("t5_no_resp", 128'(n_resp), 128'(0));
        chk("t5_grant_after_resp", 128'(last_grant_cyc - last_resp_cyc), 128'(1));
        ld_req_valid = 1'b0;
        repeat (10) tick();

        // Reset during S_WAIT abandons the store; a late dmem_resp is ignored
        clear_obs();
        mem_lat = 6;
        sb_req_valid = 1'b1; sb_req_addr = 32'h3000; sb_req_wmask = 4'hF; sb_req_wdata = 32'hCAFEF00D;
        tick();
        sb_req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_outputs_zero", 128'({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, ld_resp_valid,
                                     ld_resp_rob, ld_resp_rdata, ld_req_ready, sb_req_ready}), 128'(0));
        inj = 1'b1;
        tick();
        inj = 1'b0;
        repeat (4) tick();
        chk("t6_late_resp_ignored", 128'({n_resp, n_rd_cyc}), 128'(0));
        sb_req_valid = 1'b1;
        #1;
        chk("t6_idle_after_rst", 128'(sb_req_ready), 128'(1));
        tick();
        sb_req_valid = 1'b0;
        repeat (8) tick();

        // Randomized traffic against the model
        mem_lat = 0;
        for (int i = 0; i < 1500; i++) begin
            ld_req_valid = ($urandom_range(0, 9) < 6);
            ld_req_addr  = $urandom;
            ld_req_rmask = 4'($urandom_range(1, 15));
            ld_req_rob   = 3'($urandom);
            sb_req_valid = ($urandom_range(0, 9) < 5);
            sb_req_addr  = $urandom;
            sb_req_wmask = 4'($urandom_range(1, 15));
            sb_req_wdata = $urandom;
            sb_full      = ($urandom_range(0, 9) == 0);
            move_flush   = ($urandom_range(0, 9) == 0);
            inj          = !m_outst && ($urandom_range(0, 19) == 0);
            rst          = (i % 500 == 250);
            tick();
        end
        rst = 1'b0;
        quiet_inputs();
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
